// File: rtl/cartouche_banked_pkg.sv
// Shared types and constants for the banked MO cartridge memory.
package cartouche_banked_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    LOADING = 2'd1,
    READY   = 2'd2
  } cart_state_t;

  // The top ROM_SEL_SPAN bytes of the window act as bank-select registers in ROM mode.
  localparam int         ROM_SEL_SPAN = 4;
  localparam logic [7:0] FILL_BYTE    = 8'hFF;

endpackage

// File: rtl/cartouche_banked_if.sv
// CPU bus and download port of the cartridge, bundled as one interface.
interface cartouche_banked_if #(
  parameter int ADDR_W = 14,
  parameter int BANK_W = 2,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0]        cpu_addr;
  logic                     cpu_rd;
  logic                     cpu_we;
  logic [DATA_W-1:0]        cpu_din;
  logic [DATA_W-1:0]        cpu_dout;
  logic                     cpu_valid;
  logic                     dl_active;
  logic                     dl_wr;
  logic [ADDR_W+BANK_W-1:0] dl_addr;
  logic [DATA_W-1:0]        dl_data;
  logic                     dl_ack;
  logic                     cart_present;
  logic [BANK_W-1:0]        bank;

  modport master (
    output cpu_addr, cpu_rd, cpu_we, cpu_din, dl_active, dl_wr, dl_addr, dl_data,
    input  cpu_dout, cpu_valid, dl_ack, cart_present, bank
  );

  modport slave (
    input  cpu_addr, cpu_rd, cpu_we, cpu_din, dl_active, dl_wr, dl_addr, dl_data,
    output cpu_dout, cpu_valid, dl_ack, cart_present, bank
  );
endinterface

// File: rtl/cartouche_banked_dpram.sv
// Simple dual-port byte memory: one write port, one registered read port (read-before-write).
module cartouche_banked_dpram #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/cartouche_banked.sv
// Banked MO cartridge: download fill, 1-cycle CPU reads, MEMO5 bank switching or RAM writes.
//
//  state   | meaning
//  EMPTY   | no image since reset; reads return fill byte
//  LOADING | download in progress; CPU writes ignored, reads return fill byte
//  READY   | image usable; reads/bank-select/RAM writes active
module cartouche_banked
  import cartouche_banked_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int BANK_W = 2,
  parameter int DATA_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ram_mode,
  cartouche_banked_if.slave  bus
);

  localparam int MEM_W = ADDR_W + BANK_W;
  localparam logic [ADDR_W-1:0] ROM_SEL_BASE = ADDR_W'((1 << ADDR_W) - ROM_SEL_SPAN);

  cart_state_t        state_q, state_d;
  logic               load_start, load_done;
  logic [BANK_W-1:0]  bank_reg, bank_mask, bank_eff;
  logic [MEM_W-1:0]   max_addr;
  logic               dl_ack_q, cpu_valid_q, rd_hit_q;
  logic               dl_accept, cpu_wr_ok, bank_sel_we;
  logic               mem_we;
  logic [MEM_W-1:0]   mem_waddr, mem_raddr;
  logic [DATA_W-1:0]  mem_wdata, mem_rdata;

  // Smallest all-ones mask covering the highest loaded bank index.
  function automatic logic [BANK_W-1:0] span_mask(input logic [BANK_W-1:0] hi);
    logic [BANK_W-1:0] m;
    m = hi;
    for (int i = 1; i < BANK_W; i++) m = m | (m >> i);
    return m;
  endfunction

  always_comb begin
    state_d    = state_q;
    load_start = 1'b0;
    load_done  = 1'b0;
    case (state_q)
      EMPTY, READY: if (bus.dl_active) begin
        state_d    = LOADING;
        load_start = 1'b1;
      end
      LOADING: if (!bus.dl_active) begin
        state_d   = READY;
        load_done = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
  end

  assign bank_eff    = bank_reg & bank_mask;
  assign dl_accept   = bus.dl_active & bus.dl_wr;
  assign cpu_wr_ok   = bus.cpu_we & (state_q == READY) & ram_mode & ~dl_accept;
  assign bank_sel_we = bus.cpu_we & (state_q == READY) & ~ram_mode & ~dl_accept
                       & (bus.cpu_addr >= ROM_SEL_BASE);

  // Download traffic owns the single write port whenever it is present.
  assign mem_we    = dl_accept | cpu_wr_ok;
  assign mem_waddr = dl_accept ? bus.dl_addr : {bank_eff, bus.cpu_addr};
  assign mem_wdata = dl_accept ? bus.dl_data : bus.cpu_din;
  assign mem_raddr = {bank_eff, bus.cpu_addr};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      bank_reg    <= '0;
      bank_mask   <= '0;
      max_addr    <= '0;
      dl_ack_q    <= 1'b0;
      cpu_valid_q <= 1'b0;
      rd_hit_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      dl_ack_q    <= dl_accept;
      cpu_valid_q <= bus.cpu_rd;
      rd_hit_q    <= bus.cpu_rd & (state_q == READY);
      if (load_start)
        max_addr <= dl_accept ? bus.dl_addr : '0;
      else if (dl_accept && (bus.dl_addr > max_addr))
        max_addr <= bus.dl_addr;
      if (load_done) begin
        bank_mask <= span_mask(max_addr[MEM_W-1:ADDR_W]);
        bank_reg  <= '0;
      end else if (bank_sel_we) begin
        bank_reg  <= bus.cpu_addr[BANK_W-1:0];
      end
    end
  end

  cartouche_banked_dpram #(.AW(MEM_W), .DW(DATA_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  assign bus.cpu_dout     = rd_hit_q ? mem_rdata : DATA_W'(FILL_BYTE);
  assign bus.cpu_valid    = cpu_valid_q;
  assign bus.dl_ack       = dl_ack_q;
  assign bus.cart_present = (state_q == READY);
  assign bus.bank         = bank_eff;

endmodule

// File: tb/tb_cartouche_banked.sv
// Directed + randomized bench for cartouche_banked against a byte-array cartridge model.
module tb_cartouche_banked;

  localparam int ADDR_W = 14;
  localparam int BANK_W = 2;
  localparam int DATA_W = 8;
  localparam int WIN    = 1 << ADDR_W;

  logic clk;
  logic reset_n;
  logic ram_mode;

  cartouche_banked_if #(.ADDR_W(ADDR_W), .BANK_W(BANK_W), .DATA_W(DATA_W)) bus ();

  cartouche_banked #(.ADDR_W(ADDR_W), .BANK_W(BANK_W), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ram_mode (ram_mode),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: cartridge image, loaded flag, bank register and wrap mask.
  logic [7:0] m_mem [0:65535];
  bit         m_ready;
  int         m_bank_reg;
  int         m_mask;
  int         m_max;

  function automatic int eff_bank();
    return m_bank_reg & m_mask;
  endfunction

  function automatic int mask_from_max(input int max_addr);
    int nbanks, p;
    nbanks = max_addr / WIN + 1;
    p = 1;
    while (p < nbanks) p = p * 2;
    return p - 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_read(input int addr, input string tag);
    logic [7:0] exp;
    exp = m_ready ? m_mem[eff_bank() * WIN + addr] : 8'hFF;
    bus.cpu_addr = ADDR_W'(addr);
    bus.cpu_rd   = 1'b1;
    tick();
    bus.cpu_rd   = 1'b0;
    check({tag, "_valid"}, 32'(bus.cpu_valid), 32'd1);
    check({tag, "_dout"},  32'(bus.cpu_dout),  32'(exp));
  endtask

  task automatic cpu_write(input int addr, input logic [7:0] data);
    bus.cpu_addr = ADDR_W'(addr);
    bus.cpu_din  = data;
    bus.cpu_we   = 1'b1;
    tick();
    bus.cpu_we   = 1'b0;
    if (m_ready) begin
      if (ram_mode) m_mem[eff_bank() * WIN + addr] = data;
      else if (addr >= WIN - 4) m_bank_reg = addr % 4;
    end
  endtask

  task automatic dl_byte(input int addr, input logic [7:0] data);
    bus.dl_addr = (ADDR_W + BANK_W)'(addr);
    bus.dl_data = data;
    bus.dl_wr   = 1'b1;
    tick();
    m_mem[addr] = data;
    if (addr > m_max) m_max = addr;
  endtask

  task automatic dl_begin();
    bus.dl_active = 1'b1;
    tick();
    m_ready = 1'b0;
    m_max   = 0;
  endtask

  task automatic dl_end();
    bus.dl_wr = 1'b0;
    tick();
    bus.dl_active = 1'b0;
    tick();
    m_ready    = 1'b1;
    m_mask     = mask_from_max(m_max);
    m_bank_reg = 0;
  endtask

  initial begin
    int ack_miss;
    int a, op;
    logic [7:0] d, old;

    reset_n       = 1'b0;
    ram_mode      = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_rd    = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_din   = '0;
    bus.dl_active = 1'b0;
    bus.dl_wr     = 1'b0;
    bus.dl_addr   = '0;
    bus.dl_data   = '0;
    m_ready = 0; m_bank_reg = 0; m_mask = 0; m_max = 0;
    tick();
    tick();
    check("rst_valid", 32'(bus.cpu_valid),    32'd0);
    check("rst_dout",  32'(bus.cpu_dout),     32'hFF);
    check("rst_ack",   32'(bus.dl_ack),       32'd0);
    check("rst_cart",  32'(bus.cart_present), 32'd0);
    check("rst_bank",  32'(bus.bank),         32'd0);
    reset_n = 1'b1;

    cpu_read(0, "empty_rd");
    check("empty_cart", 32'(bus.cart_present), 32'd0);
    tick();
    check("valid_pulse", 32'(bus.cpu_valid), 32'd0);

    // 32 KB download: bank 0 = 0x00, bank 1 = 0x11, ack checked every byte.
    dl_begin();
    cpu_read(16, "load_rd");
    cpu_write(16, 8'h99);
    check("load_cart", 32'(bus.cart_present), 32'd0);
    ack_miss = 0;
    for (int i = 0; i < 2 * WIN; i++) begin
      dl_byte(i, (i < WIN) ? 8'h00 : 8'h11);
      if (bus.dl_ack !== 1'b1) ack_miss++;
    end
    check("dl_ack_all", 32'(ack_miss), 32'd0);
    dl_end();
    check("ready_cart", 32'(bus.cart_present), 32'd1);
    check("ready_bank", 32'(bus.bank),         32'd0);
    check("ready_ack",  32'(bus.dl_ack),       32'd0);
    cpu_read(16, "rd_b0");
    check("rd_b0_val", 32'(bus.cpu_dout), 32'h00);

    // ROM mode bank switching, with wrap through the 2-bank mask.
    cpu_write(WIN - 3, 8'h00);
    check("rom_bank1", 32'(bus.bank), 32'd1);
    cpu_read(16, "rd_b1");
    check("rd_b1_val", 32'(bus.cpu_dout), 32'h11);
    cpu_write(WIN - 2, 8'h00);
    check("rom_wrap", 32'(bus.bank), 32'd0);

    for (int k = 0; k < 300; k++) begin
      op = $urandom_range(0, 2);
      if (op == 0) cpu_read($urandom_range(0, WIN - 1), "rom_rnd_rd");
      else if (op == 1) cpu_write(WIN - 4 + $urandom_range(0, 3), 8'($urandom));
      else cpu_write($urandom_range(0, WIN - 5), 8'($urandom));
      check("rom_rnd_bank", 32'(bus.bank), 32'(eff_bank()));
    end
    cpu_write(WIN - 4, 8'h00);
    check("rom_bank0", 32'(bus.bank), 32'd0);

    // RAM mode: writes land in the mapped bank, bank register frozen.
    ram_mode = 1'b1;
    cpu_write(16'h0100, 8'h5A);
    cpu_read(16'h0100, "ram_rd");
    check("ram_rd_val", 32'(bus.cpu_dout), 32'h5A);
    cpu_write(WIN - 1, 8'h33);
    check("ram_bank_frozen", 32'(bus.bank), 32'd0);
    cpu_read(WIN - 1, "ram_top_rd");
    for (int k = 0; k < 200; k++) begin
      a = $urandom_range(16'h0300, WIN - 1);
      if ($urandom_range(0, 1) == 0) cpu_read(a, "ram_rnd_rd");
      else cpu_write(a, 8'($urandom));
    end
    check("ram_rnd_bank", 32'(bus.bank), 32'd0);

    // Same-cycle read and write: read sees the old byte.
    old = m_mem[16'h0200];
    bus.cpu_addr = ADDR_W'(16'h0200);
    bus.cpu_din  = 8'h77;
    bus.cpu_rd   = 1'b1;
    bus.cpu_we   = 1'b1;
    tick();
    bus.cpu_rd   = 1'b0;
    bus.cpu_we   = 1'b0;
    m_mem[16'h0200] = 8'h77;
    check("rbw_old", 32'(bus.cpu_dout), 32'(old));
    check("rbw_old_const", 32'(bus.cpu_dout), 32'h00);
    cpu_read(16'h0200, "rbw_new");
    check("rbw_new_val", 32'(bus.cpu_dout), 32'h77);

    // Download strobe without dl_active is ignored.
    bus.dl_addr = 16'h0100;
    bus.dl_data = 8'hEE;
    bus.dl_wr   = 1'b1;
    tick();
    bus.dl_wr   = 1'b0;
    check("dl_idle_ack", 32'(bus.dl_ack), 32'd0);
    cpu_read(16'h0100, "dl_idle_rd");

    // Reset in the middle of a download, then a short one-bank image.
    ram_mode = 1'b0;
    dl_begin();
    for (int i = 0; i < 4; i++) dl_byte(i, 8'hA0 + 8'(i));
    reset_n = 1'b0;
    bus.dl_wr = 1'b0;
    bus.dl_active = 1'b0;
    tick();
    m_ready = 0; m_bank_reg = 0; m_mask = 0;
    reset_n = 1'b1;
    check("mid_rst_cart", 32'(bus.cart_present), 32'd0);
    check("mid_rst_bank", 32'(bus.bank),         32'd0);
    check("mid_rst_ack",  32'(bus.dl_ack),       32'd0);
    cpu_read(2, "mid_rst_rd");
    dl_begin();
    for (int i = 0; i < 64; i++) begin
      d = 8'($urandom);
      dl_byte(i, d);
      check("dl2_ack", 32'(bus.dl_ack), 32'd1);
    end
    dl_end();
    check("dl2_cart", 32'(bus.cart_present), 32'd1);
    check("dl2_bank", 32'(bus.bank),         32'd0);
    for (int k = 0; k < 8; k++) cpu_read($urandom_range(0, 63), "dl2_rd");
    cpu_write(WIN - 1, 8'h00);
    check("dl2_wrap", 32'(bus.bank), 32'd0);
    cpu_read(5, "dl2_wrap_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
